sysmon_host_link: RTL and testbench

Host-side endpoint of the system monitor UART packet link. It parses the monitor's outgoing telemetry frames (battery voltage, buttons, audio/brightness, system control, PMIC status, version) into per-channel shadow registers with update strobes. It also serialises host commands (button/version requests, system-control and brightness writes) into frames towards the monitor. It sits between a byte UART (rx strobe / tx busy) and host logic or the ESP32 bridge.

---
 rtl/sysmon_host_link.sv | 242 ++++++++++++++++++++++++
 tb/tb_sysmon_host_link.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysmon_host_link.sv
// Host-side endpoint of the system monitor UART packet link: telemetry frame parser plus command framer.
// Define SYSMON_HOST_CHECKSUM_EN to add a trailing XOR checksum byte in both directions.
module sysmon_host_link #(
  parameter int IDLE_TIMEOUT = 8192,
  parameter int NUM_CH       = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             uart_rx_data,
  input  logic                   uart_rx_val,
  input  logic                   uart_tx_busy,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_val,
  input  logic [6:0]             cmd_addr,
  input  logic [13:0]            cmd_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [NUM_CH*14-1:0]   ch_value,
  output logic [NUM_CH-1:0]      ch_update,
  output logic                   frame_error,
  output logic [7:0]             error_count
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_LEN, RX_D0, RX_D1
`ifdef SYSMON_HOST_CHECKSUM_EN
    , RX_CSUM
`endif
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_HDR, TX_LEN, TX_D0, TX_D1
`ifdef SYSMON_HOST_CHECKSUM_EN
    , TX_CSUM
`endif
  } tx_state_e;

  rx_state_e             rx_state_q, rx_state_d;
  logic [6:0]            rx_addr_q, rx_addr_d;
  logic [5:0]            rx_hi_q, rx_hi_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [NUM_CH*14-1:0]  ch_value_q, ch_value_d;
  logic [NUM_CH-1:0]     ch_update_q, ch_update_d;
  logic                  frame_error_q, rx_err;
  logic [7:0]            error_count_q;
  logic                  commit;
  logic [13:0]           commit_val;
`ifdef SYSMON_HOST_CHECKSUM_EN
  logic [7:0]            rx_lo_q, rx_lo_d;
  logic [7:0]            rx_csum_q, rx_csum_d;
`endif

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_addr_d   = rx_addr_q;
    rx_hi_d     = rx_hi_q;
    timer_d     = timer_q;
    ch_value_d  = ch_value_q;
    ch_update_d = '0;
    rx_err      = 1'b0;
    commit      = 1'b0;
    commit_val  = '0;
`ifdef SYSMON_HOST_CHECKSUM_EN
    rx_lo_d     = rx_lo_q;
    rx_csum_d   = rx_csum_q;
`endif
    // Idle timer only runs mid-frame; expiry abandons the partial frame.
    if (rx_state_q != RX_IDLE && !uart_rx_val) begin
      if (timer_q == '0) begin
        rx_err     = 1'b1;
        rx_state_d = RX_IDLE;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
    if (uart_rx_val) begin
      timer_d = TW'(IDLE_TIMEOUT - 1);
`ifdef SYSMON_HOST_CHECKSUM_EN
      rx_csum_d = rx_csum_q ^ uart_rx_data;
`endif
      case (rx_state_q)
        RX_IDLE: begin
          if (uart_rx_data[7]) begin
            rx_addr_d  = uart_rx_data[6:0];
            rx_state_d = RX_LEN;
`ifdef SYSMON_HOST_CHECKSUM_EN
            rx_csum_d  = uart_rx_data;
`endif
          end else begin
            rx_err = 1'b1;
          end
        end
        RX_LEN: begin
          if (uart_rx_data == 8'h02) begin
            rx_state_d = RX_D0;
          end else begin
            rx_err     = 1'b1;
            rx_state_d = RX_IDLE;
          end
        end
        RX_D0: begin
          rx_hi_d    = uart_rx_data[5:0];
          rx_state_d = RX_D1;
        end
        RX_D1: begin
`ifdef SYSMON_HOST_CHECKSUM_EN
          rx_lo_d    = uart_rx_data;
          rx_state_d = RX_CSUM;
`else
          commit     = 1'b1;
          commit_val = {rx_hi_q, uart_rx_data};
          rx_state_d = RX_IDLE;
`endif
        end
`ifdef SYSMON_HOST_CHECKSUM_EN
        RX_CSUM: begin
          if (uart_rx_data == rx_csum_q) begin
            commit     = 1'b1;
            commit_val = {rx_hi_q, rx_lo_q};
          end else begin
            rx_err = 1'b1;
          end
          rx_state_d = RX_IDLE;
        end
`endif
        default: rx_state_d = RX_IDLE;
      endcase
    end
    // Addresses beyond the last channel match nothing and are silently dropped.
    for (int n = 0; n < NUM_CH; n++) begin
      if (commit && rx_addr_q == 7'(n)) begin
        ch_value_d[n*14 +: 14] = commit_val;
        ch_update_d[n]         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q    <= RX_IDLE;
      rx_addr_q     <= '0;
      rx_hi_q       <= '0;
      timer_q       <= '0;
      ch_value_q    <= '0;
      ch_update_q   <= '0;
      frame_error_q <= 1'b0;
      error_count_q <= '0;
`ifdef SYSMON_HOST_CHECKSUM_EN
      rx_lo_q       <= '0;
      rx_csum_q     <= '0;
`endif
    end else begin
      rx_state_q    <= rx_state_d;
      rx_addr_q     <= rx_addr_d;
      rx_hi_q       <= rx_hi_d;
      timer_q       <= timer_d;
      ch_value_q    <= ch_value_d;
      ch_update_q   <= ch_update_d;
      frame_error_q <= rx_err;
      if (rx_err && error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
`ifdef SYSMON_HOST_CHECKSUM_EN
      rx_lo_q       <= rx_lo_d;
      rx_csum_q     <= rx_csum_d;
`endif
    end
  end

  tx_state_e    tx_state_q, tx_state_d, tx_next;
  logic [6:0]   tx_addr_q, tx_addr_d;
  logic [13:0]  tx_cmd_q, tx_cmd_d;
  logic [1:0]   gap_q, gap_d;
  logic         tx_val_q, tx_val_d;
  logic [7:0]   tx_byte_q, tx_byte_d, cur_byte;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_addr_d  = tx_addr_q;
    tx_cmd_d   = tx_cmd_q;
    gap_d      = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
    tx_val_d   = 1'b0;
    tx_byte_d  = tx_byte_q;
    cur_byte   = 8'h00;
    tx_next    = TX_IDLE;
    case (tx_state_q)
      TX_HDR: begin cur_byte = {1'b1, tx_addr_q};         tx_next = TX_LEN; end
      TX_LEN: begin cur_byte = 8'h02;                     tx_next = TX_D0;  end
      TX_D0:  begin cur_byte = {2'b00, tx_cmd_q[13:8]};   tx_next = TX_D1;  end
`ifdef SYSMON_HOST_CHECKSUM_EN
      TX_D1:  begin cur_byte = tx_cmd_q[7:0];             tx_next = TX_CSUM; end
      TX_CSUM: begin
        cur_byte = {1'b1, tx_addr_q} ^ 8'h02 ^ {2'b00, tx_cmd_q[13:8]} ^ tx_cmd_q[7:0];
        tx_next  = TX_IDLE;
      end
`else
      TX_D1:  begin cur_byte = tx_cmd_q[7:0];             tx_next = TX_IDLE; end
`endif
      default: ;
    endcase
    // The strobe is registered, so a gap of two covers the strobe cycle plus one skip cycle.
    if (tx_state_q == TX_IDLE) begin
      if (cmd_valid) begin
        tx_addr_d  = cmd_addr;
        tx_cmd_d   = cmd_data;
        tx_state_d = TX_HDR;
      end
    end else if (gap_q == 2'd0 && !uart_tx_busy) begin
      tx_val_d   = 1'b1;
      tx_byte_d  = cur_byte;
      gap_d      = 2'd2;
      tx_state_d = tx_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_addr_q  <= '0;
      tx_cmd_q   <= '0;
      gap_q      <= '0;
      tx_val_q   <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_addr_q  <= tx_addr_d;
      tx_cmd_q   <= tx_cmd_d;
      gap_q      <= gap_d;
      tx_val_q   <= tx_val_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign cmd_ready    = (tx_state_q == TX_IDLE);
  assign uart_tx_val  = tx_val_q;
  assign uart_tx_data = tx_byte_q;
  assign ch_value     = ch_value_q;
  assign ch_update    = ch_update_q;
  assign frame_error  = frame_error_q;
  assign error_count  = error_count_q;

endmodule

// File: tb/tb_sysmon_host_link.sv
// Directed bench for sysmon_host_link: rx parsing, errors, timeout, tx framing under a slow UART.
module tb_sysmon_host_link;
  localparam int TO = 64;
  localparam int NC = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] uart_rx_data = '0;
  logic uart_rx_val = 1'b0;
  logic uart_tx_busy;
  logic [7:0] uart_tx_data;
  logic uart_tx_val;
  logic [6:0] cmd_addr = '0;
  logic [13:0] cmd_data = '0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [NC*14-1:0] ch_value;
  logic [NC-1:0] ch_update;
  logic frame_error;
  logic [7:0] error_count;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int upd_cnt = 0;
  int busy_cnt = 0;
  int viol = 0;
  logic [7:0] txq[$];

  sysmon_host_link #(.IDLE_TIMEOUT(TO), .NUM_CH(NC)) dut (
    .clk(clk), .reset(reset),
    .uart_rx_data(uart_rx_data), .uart_rx_val(uart_rx_val), .uart_tx_busy(uart_tx_busy),
    .uart_tx_data(uart_tx_data), .uart_tx_val(uart_tx_val),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .ch_value(ch_value), .ch_update(ch_update),
    .frame_error(frame_error), .error_count(error_count)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after every strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (uart_tx_val) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (|ch_update) upd_cnt <= upd_cnt + 1;
    if (uart_tx_val) begin
      txq.push_back(uart_tx_data);
      if (uart_tx_busy) viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] chv(input int n);
    return ch_value[n*14 +: 14];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_rx_data = b;
    uart_rx_val  = 1'b1;
    @(negedge clk);
    uart_rx_val  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] d0, input logic [7:0] d1);
    send_byte(h);
    send_byte(8'h02);
    send_byte(d0);
    send_byte(d1);
`ifdef SYSMON_HOST_CHECKSUM_EN
    send_byte(h ^ 8'h02 ^ d0 ^ d1);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_cmd(input logic [6:0] a, input logic [13:0] d, input string tag);
    logic [7:0] exp_b[5];
    int nb;
    txq.delete();
    exp_b[0] = {1'b1, a};
    exp_b[1] = 8'h02;
    exp_b[2] = {2'b00, d[13:8]};
    exp_b[3] = d[7:0];
    exp_b[4] = exp_b[0] ^ exp_b[1] ^ exp_b[2] ^ exp_b[3];
`ifdef SYSMON_HOST_CHECKSUM_EN
    nb = 5;
`else
    nb = 4;
`endif
    @(negedge clk);
    cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    chk({tag, "_ready_idle"}, cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 7'h7F; cmd_data = 14'h3FFF;
    chk({tag, "_ready_busy"}, cmd_ready, 1'b0);
    for (int i = 0; i < 400 && txq.size() < nb; i++) @(negedge clk);
    idle(40);
    chk({tag, "_nbytes"}, txq.size(), nb);
    for (int i = 0; i < nb && i < txq.size(); i++) chk({tag, "_byte"}, txq[i], exp_b[i]);
    chk({tag, "_ready_end"}, cmd_ready, 1'b1);
  endtask

  initial begin
    int e0, u0;
    logic [NC*14-1:0] snap;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst_value", ch_value, '0);
    chk("rst_update", ch_update, '0);
    chk("rst_ferr", frame_error, 1'b0);
    chk("rst_ecnt", error_count, 8'd0);
    chk("rst_txval", uart_tx_val, 1'b0);
    chk("rst_txdata", uart_tx_data, 8'd0);

    send_frame(8'h83, 8'h00, 8'h12);
    chk("ch3_update", ch_update, 7'b0001000);
    chk("ch3_value", chv(3), 14'h0012);
    idle(1);
    chk("ch3_pulse_len", ch_update, 7'b0000000);

    send_frame(8'h86, 8'h3F, 8'hFF);
    chk("ch6_value", chv(6), 14'h3FFF);
    idle(2);
    snap = ch_value; u0 = upd_cnt;
    send_frame(8'h89, 8'h01, 8'h02);
    idle(2);
    chk("oob_value", ch_value, snap);
    chk("oob_upd", upd_cnt, u0);
    chk("oob_err", fe_cnt, 0);

    send_byte(8'h80);
    send_byte(8'h03);
    idle(2);
    chk("badlen_pulse", fe_cnt, 1);
    chk("badlen_ecnt", error_count, 8'd1);
    send_frame(8'h80, 8'h06, 8'h80);
    chk("ch0_value", chv(0), 14'h0680);

    send_byte(8'h12);
    idle(2);
    chk("stray_ecnt", error_count, 8'd2);

    send_frame(8'h82, 8'hC1, 8'h23);
    chk("d0_mask", chv(2), 14'h0123);

    send_byte(8'h81);
    send_byte(8'h02);
    idle(TO - 3);
    chk("to_early", error_count, 8'd2);
    idle(10);
    chk("to_ecnt", error_count, 8'd3);
    chk("to_pulse", fe_cnt, 3);
    send_frame(8'h81, 8'h12, 8'h34);
    chk("post_to_ch1", chv(1), 14'h1234);

`ifdef SYSMON_HOST_CHECKSUM_EN
    e0 = error_count;
    send_byte(8'h84); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    idle(2);
    chk("csum_bad_ecnt", error_count, 8'(e0 + 1));
    chk("csum_bad_ch4", chv(4), 14'h0000);
`endif

    chk("no_strobe_yet", txq.size(), 0);
    run_cmd(7'd5, 14'h000A, "cmd5");
    chk("busy_viol", viol, 0);

    fork
      run_cmd(7'd6, 14'h2ABC, "cmd6");
      begin idle(5); send_frame(8'h84, 8'h15, 8'h5A); end
    join
    chk("dual_ch4", chv(4), 14'h155A);
    chk("busy_viol2", viol, 0);

    for (int i = 0; i < 300; i++) begin
`ifdef SYSMON_HOST_CHECKSUM_EN
      send_byte(8'h84); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
`else
      send_byte(8'h00);
`endif
    end
    idle(2);
    chk("ecnt_sat", error_count, 8'd255);

    txq.delete();
    @(negedge clk);
    cmd_addr = 7'd4; cmd_data = 14'h0111; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && txq.size() < 1; i++) @(negedge clk);
    send_byte(8'h83);
    reset = 1'b1;
    idle(2);
    chk("rst2_ecnt", error_count, 8'd0);
    chk("rst2_value", ch_value, '0);
    reset = 1'b0;
    idle(60);
    chk("rst2_no_tx", txq.size(), 1);
    send_frame(8'h85, 8'h00, 8'h07);
    chk("rst2_ch5", chv(5), 14'h0007);
    chk("rst2_no_err", error_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
